// File: rtl/parking_capacity_pkg.sv
// Shared parking constants and the count-width derivation.
// The gate and display blocks use these too.
package parking_capacity_pkg;

  localparam int unsigned NUM_SPOTS_DEFAULT = 4;

  // Number of bits needed to hold any value from 0 to n.
  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_capacity_spot_popcount.sv
// Combinational count of the set bits in the occupancy vector.
module spot_popcount
  import parking_capacity_pkg::*;
#(
  parameter int unsigned NUM_SPOTS = NUM_SPOTS_DEFAULT,
  localparam int unsigned CNT_W = calc_cnt_w(NUM_SPOTS)
) (
  input  logic [NUM_SPOTS-1:0] vec,
  output logic [CNT_W-1:0]     count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NUM_SPOTS; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/parking_capacity.sv
// Free-space counter. It registers the number of free spots together with the
// full/empty flags and a one-cycle pulse whenever the count changes.
module parking_capacity
  import parking_capacity_pkg::*;
#(
  parameter int unsigned NUM_SPOTS = NUM_SPOTS_DEFAULT,
  localparam int unsigned CNT_W = calc_cnt_w(NUM_SPOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SPOTS-1:0] in,
  output logic [CNT_W-1:0]     out,
  output logic                 full,
  output logic                 empty,
  output logic                 changed
);

  logic [CNT_W-1:0] occupied;
  logic [CNT_W-1:0] free_next;

  spot_popcount #(
    .NUM_SPOTS(NUM_SPOTS)
  ) u_popcount (
    .vec  (in),
    .count(occupied)
  );

  assign free_next = CNT_W'(NUM_SPOTS) - occupied;

  // The flags are registered from free_next, so they always agree with out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= CNT_W'(NUM_SPOTS);
      full    <= 1'b0;
      empty   <= 1'b1;
      changed <= 1'b0;
    end else begin
      out     <= free_next;
      full    <= (free_next == '0);
      empty   <= (free_next == CNT_W'(NUM_SPOTS));
      changed <= (free_next != out);
    end
  end

endmodule

// File: tb/tb_parking_capacity.sv
// Scoreboard bench for parking_capacity with NUM_SPOTS=4: it runs the directed
// cases first and then random occupancy with occasional resets.
module tb_parking_capacity;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [2:0] out;
    logic       full;
    logic       empty;
    logic       changed;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic [2:0]   out;
  logic         full;
  logic         empty;
  logic         changed;

  exp_t        sbq[$];
  int unsigned checks;
  int unsigned failures;
  int          model_free;
  bit          done;

  parking_capacity #(
    .NUM_SPOTS(N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .out    (out),
    .full   (full),
    .empty  (empty),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: count the free spots with plain arithmetic and push the
  // response that the next rising edge must produce.
  task automatic apply(input logic r, input logic [N-1:0] v);
    exp_t e;
    int   free_now;
    @(negedge clk);
    rst_n = r;
    in    = v;
    free_now = r ? (int'(N) - $countones(v)) : int'(N);
    e.out     = 3'(free_now);
    e.full    = r && (free_now == 0);
    e.empty   = (free_now == int'(N));
    e.changed = r && (free_now != model_free);
    model_free = free_now;
    sbq.push_back(e);
  endtask

  // Monitor: every cycle the outputs are valid, so pop one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("out",     int'(out),     int'(e.out));
        check("full",    int'(full),    int'(e.full));
        check("empty",   int'(empty),   int'(e.empty));
        check("changed", int'(changed), int'(e.changed));
      end
    end
  end

  initial begin
    int unsigned wait_cycles;
    checks     = 0;
    failures   = 0;
    done       = 1'b0;
    rst_n      = 1'b0;
    in         = '0;
    model_free = int'(N);

    apply(1'b0, 4'b1111);
    apply(1'b0, 4'b1111);
    apply(1'b1, 4'b0001);
    apply(1'b1, 4'b0000);
    apply(1'b1, 4'b0100);
    apply(1'b1, 4'b1010);
    apply(1'b1, 4'b1111);
    apply(1'b1, 4'b1110);
    for (int i = 0; i < 5; i++) apply(1'b1, 4'b1010);
    apply(1'b0, 4'b1111);
    apply(1'b1, 4'b1111);
    apply(1'b1, 4'b0000);

    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) != 0), N'($urandom));
    end

    wait_cycles = 0;
    while (sbq.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
